// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage to hazard scoreboard signal bundle
// master: ID stage (drives decoded instruction fields, receives pipeline controls)
// slave : hazard_scoreboard
interface hazard_scoreboard_if #(
    parameter int RW    = 4,
    parameter int CNT_W = 16
);
    logic             ext_stall;
    logic             id_valid;
    logic [RW-1:0]    id_rs;
    logic [RW-1:0]    id_rt;
    logic             id_use_rt;
    logic [RW-1:0]    id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic [2:0]       id_flag_en;
    logic             id_branch;
    logic             id_branchr;
    logic [2:0]       id_cond;
    logic             id_br_taken;
    logic             pc_wen;
    logic             if_id_wen;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             control_hazard;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ext_stall, id_valid, id_rs, id_rt, id_use_rt, id_rd, id_reg_write,
               id_mem_read, id_flag_en, id_branch, id_branchr, id_cond, id_br_taken,
        input  pc_wen, if_id_wen, id_ex_bubble, if_id_flush, control_hazard,
               stall_count, flush_count
    );

    modport slave (
        input  ext_stall, id_valid, id_rs, id_rt, id_use_rt, id_rd, id_reg_write,
               id_mem_read, id_flag_en, id_branch, id_branchr, id_cond, id_br_taken,
        output pc_wen, if_id_wen, id_ex_bubble, if_id_flush, control_hazard,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register/flag scoreboard with stall, bubble and branch flush control
// Ports: clk, rst (sync, active high), hif (slave modport of hazard_scoreboard_if):
//   ID instruction fields and ext_stall in; pc_wen, if_id_wen, id_ex_bubble,
//   if_id_flush, control_hazard and saturating stall/flush counters out.
module hazard_scoreboard #(
    parameter int NREG      = 16,
    parameter int RW        = 4,
    parameter int LAT_W     = 2,
    parameter int LOAD_LAT  = 1,
    parameter int ALU_LAT   = 0,
    parameter int FLAG_LAT  = 1,
    parameter int BRR_LAT   = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave hif
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [LAT_W-1:0] LD_SET   = LAT_W'(LOAD_LAT);
    localparam logic [LAT_W-1:0] ALU_SET  = LAT_W'(ALU_LAT);
    localparam logic [LAT_W-1:0] LD_BSET  = LAT_W'(LOAD_LAT + BRR_LAT);
    localparam logic [LAT_W-1:0] ALU_BSET = LAT_W'(ALU_LAT + BRR_LAT);
    localparam logic [LAT_W-1:0] FL_SET   = LAT_W'(FLAG_LAT);
    localparam logic [LAT_W-1:0] FL_INIT  = LAT_W'(FLUSH_CYC - 1);
    localparam logic [LAT_W-1:0] ONE      = LAT_W'(1);

    logic [LAT_W-1:0] cnt  [NREG];
    logic [LAT_W-1:0] bcnt [NREG];
    logic [LAT_W-1:0] fcnt [3];
    logic [0:0]       state;
    logic [LAT_W-1:0] fl_left;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic [2:0] req_flags;
    logic       src_busy, flag_busy, brr_busy, hz_stall, issue, is_br, take_branch;

    // Flags each condition code reads; bit order Z,V,N = [0],[1],[2].
    always_comb begin
        req_flags = 3'b000;
        case (hif.id_cond)
            3'b000, 3'b001:         req_flags = 3'b001;
            3'b010, 3'b100, 3'b101: req_flags = 3'b101;
            3'b011:                 req_flags = 3'b100;
            3'b110:                 req_flags = 3'b010;
            default:                req_flags = 3'b000;
        endcase
    end

    // Register 0 is hardwired zero, so any reference to it is never busy.
    always_comb begin
        is_br     = hif.id_branch | hif.id_branchr;
        src_busy  = ((hif.id_rs != '0) && (cnt[hif.id_rs] != '0)) ||
                    (hif.id_use_rt && (hif.id_rt != '0) && (cnt[hif.id_rt] != '0));
        flag_busy = is_br && (((fcnt[0] != '0) && req_flags[0]) ||
                              ((fcnt[1] != '0) && req_flags[1]) ||
                              ((fcnt[2] != '0) && req_flags[2]));
        brr_busy  = hif.id_branchr && (hif.id_rs != '0) && (bcnt[hif.id_rs] != '0);
        hz_stall  = hif.id_valid && (src_busy || flag_busy || brr_busy);
        issue     = hif.id_valid && !hz_stall && !hif.ext_stall;
        take_branch = (state == ST_RUN) && issue && is_br && hif.id_br_taken;
    end

    assign hif.pc_wen         = !(hz_stall || hif.ext_stall);
    assign hif.if_id_wen      = !(hz_stall || hif.ext_stall);
    assign hif.id_ex_bubble   = hz_stall && !hif.ext_stall;
    assign hif.control_hazard = take_branch;
    assign hif.if_id_flush    = take_branch || (state == ST_FLUSH);
    assign hif.stall_count    = stall_cnt_q;
    assign hif.flush_count    = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i]  <= '0;
                bcnt[i] <= '0;
            end
            for (int f = 0; f < 3; f++) fcnt[f] <= '0;
            state       <= ST_RUN;
            fl_left     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hz_stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);

            if (!hif.ext_stall) begin
                for (int i = 0; i < NREG; i++) begin
                    if (cnt[i] != '0)  cnt[i]  <= cnt[i] - ONE;
                    if (bcnt[i] != '0) bcnt[i] <= bcnt[i] - ONE;
                end
                for (int f = 0; f < 3; f++)
                    if (fcnt[f] != '0) fcnt[f] <= fcnt[f] - ONE;

                // Issue writes come after the decrements so the youngest writer wins.
                if (issue && hif.id_reg_write && (hif.id_rd != '0)) begin
                    cnt[hif.id_rd]  <= hif.id_mem_read ? LD_SET  : ALU_SET;
                    bcnt[hif.id_rd] <= hif.id_mem_read ? LD_BSET : ALU_BSET;
                end
                if (issue)
                    for (int f = 0; f < 3; f++)
                        if (hif.id_flag_en[f]) fcnt[f] <= FL_SET;

                case (state)
                    ST_RUN: begin
                        if (take_branch) begin
                            if (flush_cnt_q != '1)
                                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
                            fl_left <= FL_INIT;
                            if (FLUSH_CYC > 1) state <= ST_FLUSH;
                        end
                    end
                    default: begin
                        fl_left <= fl_left - ONE;
                        if (fl_left <= ONE) state <= ST_RUN;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.RW(4), .CNT_W(16)) hif ();

    hazard_scoreboard #(.FLUSH_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                         input logic use_rt, input logic [3:0] rd, input logic rw,
                         input logic mr, input logic [2:0] fl, input logic br,
                         input logic brr, input logic [2:0] cond, input logic taken);
        hif.id_valid     = v;
        hif.id_rs        = rs;
        hif.id_rt        = rt;
        hif.id_use_rt    = use_rt;
        hif.id_rd        = rd;
        hif.id_reg_write = rw;
        hif.id_mem_read  = mr;
        hif.id_flag_en   = fl;
        hif.id_branch    = br;
        hif.id_branchr   = brr;
        hif.id_cond      = cond;
        hif.id_br_taken  = taken;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        hif.ext_stall = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_val("rst_pc_wen",  hif.pc_wen, 1);
        check_val("rst_ifid_wen", hif.if_id_wen, 1);
        check_val("rst_bubble",  hif.id_ex_bubble, 0);
        check_val("rst_flush",   hif.if_id_flush, 0);
        check_val("rst_ctrl_hz", hif.control_hazard, 0);
        check_val("rst_stall_cnt", hif.stall_count, 0);
        check_val("rst_flush_cnt", hif.flush_count, 0);

        // Load-use: LD R3 then ADD R5,R3,R4
        drive(1, 0, 0, 0, 3, 1, 1, 3'b000, 0, 0, 3'b000, 0);
        check_val("ld_issue_pc_wen", hif.pc_wen, 1);
        tick();
        drive(1, 3, 4, 1, 5, 1, 0, 3'b000, 0, 0, 3'b000, 0);
        check_val("lu_stall_pc_wen", hif.pc_wen, 0);
        check_val("lu_stall_bubble", hif.id_ex_bubble, 1);
        tick();
        check_val("lu_go_pc_wen", hif.pc_wen, 1);
        check_val("lu_go_bubble", hif.id_ex_bubble, 0);
        tick();
        idle();
        check_val("lu_stall_cnt", hif.stall_count, 1);

        // Store data not read through rt, and R0 destinations, never stall
        drive(1, 0, 0, 0, 3, 1, 1, 3'b000, 0, 0, 3'b000, 0);
        tick();
        drive(1, 1, 3, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0);
        check_val("sw_no_stall", hif.pc_wen, 1);
        tick();
        drive(1, 0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 3'b000, 0);
        tick();
        drive(1, 0, 0, 1, 1, 1, 0, 3'b000, 0, 0, 3'b000, 0);
        check_val("r0_no_stall", hif.pc_wen, 1);
        tick();

        // Flag hazards: SUB sets Z,N
        drive(1, 1, 2, 1, 6, 1, 0, 3'b101, 0, 0, 3'b000, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 3'b001, 0);
        check_val("flag_z_stall", hif.id_ex_bubble, 1);
        tick();
        check_val("flag_z_go", hif.pc_wen, 1);
        tick();
        drive(1, 1, 2, 1, 6, 1, 0, 3'b101, 0, 0, 3'b000, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 3'b110, 0);
        check_val("flag_v_no_stall", hif.id_ex_bubble, 0);
        tick();
        drive(1, 1, 2, 1, 6, 1, 0, 3'b101, 0, 0, 3'b000, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 3'b111, 0);
        check_val("flag_uncond_no_stall", hif.id_ex_bubble, 0);
        tick();
        idle();
        check_val("flag_stall_cnt", hif.stall_count, 2);

        // ADD R2 then taken BR R2: one BRR stall, then two-cycle flush
        drive(1, 0, 0, 0, 2, 1, 0, 3'b000, 0, 0, 3'b000, 0);
        tick();
        drive(1, 2, 0, 0, 0, 0, 0, 3'b000, 0, 1, 3'b111, 1);
        check_val("brr_stall_bubble", hif.id_ex_bubble, 1);
        check_val("brr_stall_no_ch", hif.control_hazard, 0);
        tick();
        check_val("brr_taken_ch", hif.control_hazard, 1);
        check_val("brr_taken_flush", hif.if_id_flush, 1);
        check_val("brr_taken_pc_wen", hif.pc_wen, 1);
        tick();
        idle();
        check_val("flush2_flush", hif.if_id_flush, 1);
        check_val("flush2_ch", hif.control_hazard, 0);
        tick();
        check_val("flush_end", hif.if_id_flush, 0);
        check_val("flush_cnt", hif.flush_count, 1);
        check_val("brr_stall_cnt", hif.stall_count, 3);

        // ext_stall freezes the load countdown
        drive(1, 0, 0, 0, 3, 1, 1, 3'b000, 0, 0, 3'b000, 0);
        tick();
        idle();
        hif.ext_stall = 1'b1;
        #1;
        check_val("ext_pc_wen", hif.pc_wen, 0);
        check_val("ext_bubble", hif.id_ex_bubble, 0);
        tick();
        tick();
        tick();
        hif.ext_stall = 1'b0;
        drive(1, 3, 0, 0, 7, 1, 0, 3'b000, 0, 0, 3'b000, 0);
        check_val("ext_release_stall", hif.id_ex_bubble, 1);
        tick();
        check_val("ext_release_go", hif.pc_wen, 1);
        tick();
        idle();
        check_val("ext_stall_cnt", hif.stall_count, 4);

        // Reset mid-flight: taken branch that also loads R3, then rst during FLUSH
        drive(1, 0, 0, 0, 3, 1, 1, 3'b000, 1, 0, 3'b111, 1);
        check_val("pre_rst_ch", hif.control_hazard, 1);
        tick();
        drive(1, 3, 0, 0, 8, 1, 0, 3'b000, 0, 0, 3'b000, 0);
        check_val("pre_rst_flush", hif.if_id_flush, 1);
        check_val("pre_rst_stall", hif.id_ex_bubble, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_val("post_rst_pc_wen", hif.pc_wen, 1);
        check_val("post_rst_bubble", hif.id_ex_bubble, 0);
        check_val("post_rst_flush", hif.if_id_flush, 0);
        check_val("post_rst_ch", hif.control_hazard, 0);
        check_val("post_rst_stall_cnt", hif.stall_count, 0);
        check_val("post_rst_flush_cnt", hif.flush_count, 0);
        tick();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
